// File: rtl/bcd_to_binary_pkg.sv
// Shared scoreboard definitions: BCD digit constants, the converter state
// encoding and the per-digit correction used by reverse double-dabble.
package bcd_to_binary_pkg;

  localparam int DIGIT_W = 4;
  localparam int OUT_W   = 8;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    DONE_ERR
  } state_t;

  // A field that reached 8 after a right shift held a borrowed ten; remove the 3 excess.
  function automatic logic [DIGIT_W-1:0] adjust_digit(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/busy/done handshake and data bus of the BCD-to-binary converter.
interface bcd_to_binary_if #(
  parameter int OUT_W = bcd_to_binary_pkg::OUT_W
);
  logic             start;
  logic [3:0]       hundreds_in;
  logic [3:0]       tens_in;
  logic [3:0]       ones_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] binary_out;
  logic             overflow;
  logic             error;

  modport master (
    output start, hundreds_in, tens_in, ones_in,
    input  busy, done, binary_out, overflow, error
  );

  modport slave (
    input  start, hundreds_in, tens_in, ones_in,
    output busy, done, binary_out, overflow, error
  );
endinterface

// File: rtl/bcd_shift_adjust.sv
// One reverse double-dabble step: shift the whole register right by one,
// then correct every BCD field that landed at 8 or above.
module bcd_shift_adjust
  import bcd_to_binary_pkg::*;
#(
  parameter  int DIGITS = 3,
  parameter  int WORK_W = 10,
  localparam int REG_W  = DIGIT_W * DIGITS + WORK_W
) (
  input  logic [REG_W-1:0] i_shift,
  output logic [REG_W-1:0] o_shift
);

  logic [REG_W-1:0] w_shifted;

  assign w_shifted = i_shift >> 1;

  // The binary work field only collects bits; no correction applies there.
  assign o_shift[WORK_W-1:0] = w_shifted[WORK_W-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign o_shift[WORK_W + DIGIT_W*d +: DIGIT_W] =
      adjust_digit(w_shifted[WORK_W + DIGIT_W*d +: DIGIT_W]);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential three-digit BCD to 8-bit binary converter (reverse double-dabble),
// one shift per clock, with saturation on overflow and a bad-digit error path.
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int WORK_W = 10,
  parameter int OUT_W  = bcd_to_binary_pkg::OUT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_binary_if.slave  bus
);
  import bcd_to_binary_pkg::*;

  localparam int REG_W = DIGIT_W * DIGITS + WORK_W;
  localparam int CNT_W = $clog2(WORK_W + 1);

  state_t             r_state;
  logic [REG_W-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [OUT_W-1:0]   r_binary;
  logic               r_overflow;
  logic               r_error;

  logic [DIGIT_W*DIGITS-1:0] w_digits;
  logic                      w_digit_err;
  logic [REG_W-1:0]          w_next_shift;
  logic [WORK_W-1:0]         w_bin;
  logic                      w_ovf;

  assign w_digits    = {bus.hundreds_in, bus.tens_in, bus.ones_in};
  assign w_digit_err = (bus.hundreds_in > BCD_MAX) || (bus.tens_in > BCD_MAX) ||
                       (bus.ones_in > BCD_MAX);

  assign w_bin = r_shift[WORK_W-1:0];
  assign w_ovf = (w_bin > WORK_W'({OUT_W{1'b1}}));

  bcd_shift_adjust #(
    .DIGITS (DIGITS),
    .WORK_W (WORK_W)
  ) u_shift_adjust (
    .i_shift (r_shift),
    .o_shift (w_next_shift)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_binary   <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_shift <= {w_digits, {WORK_W{1'b0}}};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= w_digit_err ? DONE_ERR : SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= w_next_shift;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WORK_W - 1)) r_state <= DONE;
        end
        DONE: begin
          r_binary   <= w_ovf ? {OUT_W{1'b1}} : w_bin[OUT_W-1:0];
          r_overflow <= w_ovf;
          r_error    <= 1'b0;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        DONE_ERR: begin
          r_binary   <= '0;
          r_overflow <= 1'b0;
          r_error    <= 1'b1;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.binary_out = r_binary;
  assign bus.overflow   = r_overflow;
  assign bus.error      = r_error;

endmodule
